// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl
// Chaining-mode controller between a 128-bit plaintext stream and an AES core
// whose result comes back as a narrow beat stream. Applies ECB, CBC or CTR
// around the core, reassembles the core result and re-serialises it at OUT_W.
// Optional CTR path (counter adder, PlainR xor): define AES_MODE_CTR_EN.
//
// state   | meaning
// IDLE    | wait for a plaintext block; apply IvLoad (immediate or pending)
// ISSUE   | present the mode operand to the core until it is accepted
// COLLECT | shift CORE_W core beats into the collection buffer
// EMIT    | send the mode-corrected result as OUT_W beats, MSB-first
module aes_mode_ctrl #(
    parameter int OUT_W  = 8,
    parameter int CORE_W = 8
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic [1:0]          Mode,
    input  logic [127:0]        Iv,
    input  logic                IvLoad,

    input  logic [127:0]        s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,

    output logic [OUT_W-1:0]    m_axis_tdata,
    output logic [OUT_W/8-1:0]  m_axis_tkeep,
    output logic [OUT_W/8-1:0]  m_axis_tstrb,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [7:0]          m_axis_tid,
    output logic [7:0]          m_axis_tdest,
    output logic                m_axis_tuser,

    output logic [127:0]        core_m_axis_tdata,
    output logic [15:0]         core_m_axis_tkeep,
    output logic [15:0]         core_m_axis_tstrb,
    output logic                core_m_axis_tvalid,
    input  logic                core_m_axis_tready,
    output logic                core_m_axis_tlast,
    output logic [7:0]          core_m_axis_tid,
    output logic [7:0]          core_m_axis_tdest,
    output logic                core_m_axis_tuser,

    input  logic [CORE_W-1:0]   core_s_axis_tdata,
    input  logic                core_s_axis_tvalid,
    output logic                core_s_axis_tready,

    output logic                Busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, EMIT} state_t;

    localparam logic [1:0] MODE_ECB = 2'b00;
    localparam logic [1:0] MODE_CBC = 2'b01;
`ifdef AES_MODE_CTR_EN
    localparam logic [1:0] MODE_CTR = 2'b10;
`endif

    // Down-counter reload values: beats remaining after the current one.
    localparam logic [4:0] CORE_LAST = 5'(128 / CORE_W - 1);
    localparam logic [4:0] OUT_LAST  = 5'(128 / OUT_W - 1);

    state_t         state_r, state_nxt;
    logic [1:0]     mode_r, pend_mode_r;
    logic [127:0]   iv_r, pend_iv_r, chain_r, col_r, res_r;
`ifdef AES_MODE_CTR_EN
    logic [127:0]   plain_r;
`endif
    logic           last_r, pend_r, pend_nxt;
    logic [4:0]     cnt_r;

    logic           s_tready_r, m_tvalid_r, m_tlast_r, core_tvalid_r, core_s_tready_r, busy_r;
    logic [OUT_W-1:0] m_tdata_r;
    logic [127:0]   core_tdata_r;

    logic           accept, issue_done, col_beat, col_done, emit_beat, emit_done;
    logic           iv_now, pend_apply;
    logic [127:0]   operand, col_full, res_full, res_sh;

    // Reserved mode, and CTR when the counter path is absent, fall back to ECB.
    function automatic logic [1:0] lat_mode(input logic [1:0] m);
        case (m)
            MODE_CBC: lat_mode = MODE_CBC;
`ifdef AES_MODE_CTR_EN
            MODE_CTR: lat_mode = MODE_CTR;
`endif
            default:  lat_mode = MODE_ECB;
        endcase
    endfunction

    // IvLoad gates tready in the same cycle so it always wins over a new block.
    assign s_axis_tready      = s_tready_r & ~IvLoad;
    assign m_axis_tdata       = m_tdata_r;
    assign m_axis_tvalid      = m_tvalid_r;
    assign m_axis_tlast       = m_tlast_r;
    assign m_axis_tkeep       = '0;
    assign m_axis_tstrb       = '0;
    assign m_axis_tid         = '0;
    assign m_axis_tdest       = '0;
    assign m_axis_tuser       = 1'b0;
    assign core_m_axis_tdata  = core_tdata_r;
    assign core_m_axis_tvalid = core_tvalid_r;
    assign core_m_axis_tkeep  = '0;
    assign core_m_axis_tstrb  = '0;
    assign core_m_axis_tlast  = 1'b0;
    assign core_m_axis_tid    = '0;
    assign core_m_axis_tdest  = '0;
    assign core_m_axis_tuser  = 1'b0;
    assign core_s_axis_tready = core_s_tready_r;
    assign Busy               = busy_r;

    assign iv_now     = (state_r == IDLE) && IvLoad;
    assign pend_apply = (state_r == IDLE) && pend_r && !IvLoad;

    // State register.
    always_ff @(posedge Clk) begin
        if (!RstN) state_r <= IDLE;
        else       state_r <= state_nxt;
    end

    // Next-state decode and per-state handshake strobes.
    always_comb begin
        state_nxt  = state_r;
        accept     = 1'b0;
        issue_done = 1'b0;
        col_beat   = 1'b0;
        col_done   = 1'b0;
        emit_beat  = 1'b0;
        emit_done  = 1'b0;
        pend_nxt   = pend_r;
        if (state_r == IDLE)   pend_nxt = 1'b0;
        else if (IvLoad)       pend_nxt = 1'b1;
        case (state_r)
            IDLE: begin
                if (s_axis_tready && s_axis_tvalid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (core_m_axis_tready) begin
                    issue_done = 1'b1;
                    state_nxt  = COLLECT;
                end
            end
            COLLECT: begin
                if (core_s_axis_tvalid) begin
                    col_beat = 1'b1;
                    if (cnt_r == 5'd0) begin
                        col_done  = 1'b1;
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (m_axis_tready) begin
                    emit_beat = 1'b1;
                    if (cnt_r == 5'd0) begin
                        emit_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mode operand, collection shift and result formation.
    always_comb begin
        case (mode_r)
            MODE_CBC: operand = s_axis_tdata ^ chain_r;
`ifdef AES_MODE_CTR_EN
            MODE_CTR: operand = chain_r;
`endif
            default:  operand = s_axis_tdata;
        endcase
        col_full = (col_r << CORE_W) | 128'(core_s_axis_tdata);
        res_full = col_full;
`ifdef AES_MODE_CTR_EN
        if (mode_r == MODE_CTR) res_full = plain_r ^ col_full;
`endif
        res_sh = res_r << OUT_W;
    end

    // Datapath, chain/IV bookkeeping and registered outputs.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            mode_r          <= MODE_ECB;
            pend_mode_r     <= MODE_ECB;
            iv_r            <= '0;
            pend_iv_r       <= '0;
            chain_r         <= '0;
            col_r           <= '0;
            res_r           <= '0;
`ifdef AES_MODE_CTR_EN
            plain_r         <= '0;
`endif
            last_r          <= 1'b0;
            pend_r          <= 1'b0;
            cnt_r           <= '0;
            s_tready_r      <= 1'b0;
            m_tvalid_r      <= 1'b0;
            m_tlast_r       <= 1'b0;
            m_tdata_r       <= '0;
            core_tvalid_r   <= 1'b0;
            core_tdata_r    <= '0;
            core_s_tready_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            pend_r     <= pend_nxt;
            s_tready_r <= (state_nxt == IDLE) && !pend_nxt;
            busy_r     <= (state_nxt != IDLE);

            // Keep the latest IvLoad seen mid-block for the next IDLE entry.
            if (IvLoad && state_r != IDLE) begin
                pend_iv_r   <= Iv;
                pend_mode_r <= Mode;
            end
            if (iv_now) begin
                mode_r  <= lat_mode(Mode);
                iv_r    <= Iv;
                chain_r <= Iv;
            end else if (pend_apply) begin
                mode_r  <= lat_mode(pend_mode_r);
                iv_r    <= pend_iv_r;
                chain_r <= pend_iv_r;
            end

            if (accept) begin
`ifdef AES_MODE_CTR_EN
                plain_r       <= s_axis_tdata;
`endif
                last_r        <= s_axis_tlast;
                core_tvalid_r <= 1'b1;
                core_tdata_r  <= operand;
            end

            if (issue_done) begin
                core_tvalid_r   <= 1'b0;
                core_s_tready_r <= 1'b1;
                cnt_r           <= CORE_LAST;
            end

            if (col_beat) begin
                col_r <= col_full;
                if (col_done) begin
                    core_s_tready_r <= 1'b0;
                    res_r           <= res_full;
                    m_tvalid_r      <= 1'b1;
                    m_tdata_r       <= res_full[127 -: OUT_W];
                    m_tlast_r       <= last_r && (OUT_LAST == 5'd0);
                    cnt_r           <= OUT_LAST;
                    case (mode_r)
                        MODE_CBC: chain_r <= col_full;
`ifdef AES_MODE_CTR_EN
                        MODE_CTR: chain_r <= chain_r + 128'd1;
`endif
                        default:  chain_r <= chain_r;
                    endcase
                end else begin
                    cnt_r <= cnt_r - 5'd1;
                end
            end

            if (emit_beat) begin
                if (emit_done) begin
                    m_tvalid_r <= 1'b0;
                    m_tlast_r  <= 1'b0;
                    // A finished message restarts the chain from the latched IV.
                    if (last_r) chain_r <= iv_r;
                end else begin
                    res_r     <= res_sh;
                    m_tdata_r <= res_sh[127 -: OUT_W];
                    m_tlast_r <= last_r && (cnt_r == 5'd1);
                    cnt_r     <= cnt_r - 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl. The AES core is replaced by a keyed bijective
// stand-in: the controller never looks inside the cipher, so the chaining
// rules are checked against a mode model that uses the same stand-in.
module tb_aes_mode_ctrl;

    localparam int OUT_W  = 16;
    localparam int CORE_W = 32;
    localparam int NOB    = 128 / OUT_W;
    localparam int NCB    = 128 / CORE_W;
`ifdef AES_MODE_CTR_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    logic               Clk, RstN, IvLoad;
    logic [1:0]         Mode;
    logic [127:0]       Iv;
    logic [127:0]       s_axis_tdata;
    logic               s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [OUT_W-1:0]   m_axis_tdata;
    logic [OUT_W/8-1:0] m_axis_tkeep, m_axis_tstrb;
    logic               m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [7:0]         m_axis_tid, m_axis_tdest;
    logic [127:0]       core_m_axis_tdata;
    logic [15:0]        core_m_axis_tkeep, core_m_axis_tstrb;
    logic               core_m_axis_tvalid, core_m_axis_tready, core_m_axis_tlast, core_m_axis_tuser;
    logic [7:0]         core_m_axis_tid, core_m_axis_tdest;
    logic [CORE_W-1:0]  core_s_axis_tdata;
    logic               core_s_axis_tvalid, core_s_axis_tready;
    logic               Busy;

    aes_mode_ctrl #(.OUT_W(OUT_W), .CORE_W(CORE_W)) dut (
        .Clk(Clk), .RstN(RstN), .Mode(Mode), .Iv(Iv), .IvLoad(IvLoad),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .core_m_axis_tdata(core_m_axis_tdata), .core_m_axis_tkeep(core_m_axis_tkeep),
        .core_m_axis_tstrb(core_m_axis_tstrb), .core_m_axis_tvalid(core_m_axis_tvalid),
        .core_m_axis_tready(core_m_axis_tready), .core_m_axis_tlast(core_m_axis_tlast),
        .core_m_axis_tid(core_m_axis_tid), .core_m_axis_tdest(core_m_axis_tdest),
        .core_m_axis_tuser(core_m_axis_tuser),
        .core_s_axis_tdata(core_s_axis_tdata), .core_s_axis_tvalid(core_s_axis_tvalid),
        .core_s_axis_tready(core_s_axis_tready),
        .Busy(Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int tests = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Stand-in block cipher: rotate, shear and key xor (a bijection).
    function automatic logic [127:0] ciph(input logic [127:0] x);
        logic [127:0] k;
        k = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
        return {x[114:0], x[127:115]} ^ {x[63:0], 64'h0} ^ k;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: mode semantics written directly from the mode definitions.
    int           md;        // 0 ECB, 1 CBC, 2 CTR
    logic [127:0] m_iv, m_chain;
    logic [OUT_W:0] exp_q[$];
    logic [127:0]   op_q[$];

    task automatic model_reset();
        md = 0; m_iv = '0; m_chain = '0;
        exp_q.delete();
        op_q.delete();
    endtask

    task automatic model_ivload(input logic [1:0] m, input logic [127:0] v);
        if (m == 2'd1)                md = 1;
        else if (m == 2'd2 && CTR_EN) md = 2;
        else                          md = 0;
        m_iv = v;
        m_chain = v;
    endtask

    task automatic model_block(input logic [127:0] p, input logic last);
        logic [127:0] op, r;
        logic [OUT_W-1:0] s;
        case (md)
            1: begin op = p ^ m_chain; r = ciph(op); m_chain = r; end
            2: begin op = m_chain; r = p ^ ciph(op); m_chain = m_chain + 128'd1; end
            default: begin op = p; r = ciph(p); end
        endcase
        if (last) m_chain = m_iv;
        op_q.push_back(op);
        for (int i = 0; i < NOB; i++) begin
            s = r[127 - OUT_W*i -: OUT_W];
            exp_q.push_back({last && (i == NOB - 1), s});
        end
    endtask

    // Core stand-in: one block at a time, random accept and random result gaps.
    int           cm_idx;
    bit           cm_busy, cm_acc;
    logic [127:0] cm_blk;
    initial begin
        core_m_axis_tready = 1'b0;
        core_s_axis_tvalid = 1'b0;
        core_s_axis_tdata  = '0;
        cm_busy = 1'b0; cm_idx = 0; cm_blk = '0;
        forever begin
            @(negedge Clk);
            cm_acc = 1'b0;
            if (!RstN) begin
                cm_busy = 1'b0; cm_idx = 0;
            end else if (cm_busy) begin
                if (core_s_axis_tvalid && core_s_axis_tready) begin
                    cm_acc = 1'b1;
                    cm_idx++;
                    if (cm_idx == NCB) cm_busy = 1'b0;
                end
            end else if (core_m_axis_tvalid && core_m_axis_tready) begin
                tests++;
                if (op_q.size() == 0) begin
                    errors++;
                    $display("FAIL core_operand_unexpected actual=%h required=none", core_m_axis_tdata);
                end else begin
                    tests--;
                    chk("core_operand", core_m_axis_tdata, op_q.pop_front());
                end
                cm_blk = ciph(core_m_axis_tdata);
                cm_busy = 1'b1; cm_idx = 0;
            end
            @(posedge Clk); #1;
            core_m_axis_tready = !cm_busy && ($urandom_range(0, 2) != 0);
            if (cm_busy) begin
                if (!(core_s_axis_tvalid && !cm_acc)) begin
                    core_s_axis_tvalid = ($urandom_range(0, 3) != 0);
                    core_s_axis_tdata  = cm_blk[127 - CORE_W*cm_idx -: CORE_W];
                end
            end else begin
                core_s_axis_tvalid = 1'b0;
            end
        end
    end

    // m_axis ready pattern: 0 always high, 1 toggling, 2 random.
    int rdy_mode = 0;
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge Clk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    // Output monitor: pops the scoreboard on each handshake, checks stall stability.
    bit             stall_pend = 1'b0;
    logic [OUT_W:0] stall_beat;
    always @(negedge Clk) begin
        if (!RstN) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("m_stall_hold", 128'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                    128'({1'b1, stall_beat}));
                stall_pend = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL m_beat_unexpected actual=%h required=none", m_axis_tdata);
                end else begin
                    chk("m_beat", 128'({m_axis_tlast, m_axis_tdata}), 128'(exp_q.pop_front()));
                end
            end else if (m_axis_tvalid) begin
                stall_pend = 1'b1;
                stall_beat = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic iv_load(input logic [1:0] m, input logic [127:0] v);
        Mode = m; Iv = v; IvLoad = 1'b1;
        @(posedge Clk); #1;
        IvLoad = 1'b0;
        model_ivload(m, v);
    endtask

    task automatic send_block(input logic [127:0] p, input logic last);
        bit ok = 1'b0;
        s_axis_tdata = p; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            if (s_axis_tready) begin ok = 1'b1; break; end
            @(posedge Clk); #1;
        end
        if (ok) model_block(p, last);
        @(posedge Clk); #1;
        s_axis_tvalid = 1'b0;
        chk("s_accept_in_time", 128'(ok), 128'(1));
        @(negedge Clk);
        if (ok) chk("core_tvalid_next_cycle", 128'({core_m_axis_tvalid, Busy}), 128'(2'b11));
        @(posedge Clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && s_axis_tready) begin ok = 1'b1; break; end
        end
        @(posedge Clk); #1;
        chk("drain_in_time", 128'(ok), 128'(1));
    endtask

    task automatic wait_collect();
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            if (core_s_axis_tready) begin ok = 1'b1; break; end
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
        chk("collect_reached", 128'(ok), 128'(1));
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 128'({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                        core_m_axis_tvalid, core_s_axis_tready, Busy}), 128'(0));
        chk({name, "_core_tdata"}, core_m_axis_tdata, 128'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v, p;
        bit ok;
        RstN = 1'b0; IvLoad = 1'b0; Mode = 2'b00; Iv = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_all_zero("reset_outputs");
        chk("tieoffs", 128'({m_axis_tkeep, m_axis_tstrb, m_axis_tid, m_axis_tdest, m_axis_tuser,
                             core_m_axis_tkeep, core_m_axis_tstrb, core_m_axis_tid,
                             core_m_axis_tdest, core_m_axis_tuser, core_m_axis_tlast}), 128'(0));
        @(posedge Clk); #1;
        RstN = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("ready_after_reset", 128'({s_axis_tready, Busy}), 128'(2'b10));
        @(posedge Clk); #1;

        // ECB (also the reset mode), message end on the third block.
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_block(rnd128(), i == 2);
        iv_load(2'b00, rnd128());
        send_block(rnd128(), 1'b0);

        // CBC, two messages: second starts again from the latched IV.
        iv_load(2'b01, rnd128());
        for (int i = 0; i < 4; i++) send_block(rnd128(), i == 1 || i == 3);

        // CTR, then counter wrap from all-ones.
        iv_load(2'b10, rnd128());
        for (int i = 0; i < 3; i++) send_block(rnd128(), 1'b0);
        iv_load(2'b10, {128{1'b1}});
        send_block(rnd128(), 1'b0);
        send_block(rnd128(), 1'b1);

        // Reserved mode behaves as ECB.
        iv_load(2'b11, rnd128());
        send_block(rnd128(), 1'b0);

        // Toggling output ready in CBC.
        rdy_mode = 1;
        iv_load(2'b01, rnd128());
        for (int i = 0; i < 3; i++) send_block(rnd128(), i == 2);
        wait_idle();

        // IvLoad during COLLECT: current block keeps the old chain.
        rdy_mode = 2;
        iv_load(2'b01, rnd128());
        send_block(rnd128(), 1'b0);
        send_block(rnd128(), 1'b0);
        wait_collect();
        iv_load(2'b10, rnd128());
        send_block(rnd128(), 1'b0);
        send_block(rnd128(), 1'b0);
        wait_idle();

        // IvLoad beats a simultaneous tvalid in IDLE.
        v = rnd128(); p = rnd128();
        s_axis_tdata = p; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        Mode = 2'b01; Iv = v; IvLoad = 1'b1;
        @(negedge Clk);
        chk("ivload_blocks_tready", 128'(s_axis_tready), 128'(0));
        @(posedge Clk); #1;
        IvLoad = 1'b0;
        model_ivload(2'b01, v);
        send_block(p, 1'b0);

        // Random mix of loads and blocks.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 9) < 2) iv_load(2'($urandom_range(0, 3)), rnd128());
            else                          send_block(rnd128(), $urandom_range(0, 3) == 0);
        end
        wait_idle();

        // Reset in the middle of EMIT.
        rdy_mode = 0;
        send_block(rnd128(), 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            if (m_axis_tvalid) begin ok = 1'b1; break; end
            @(posedge Clk); #1;
        end
        chk("emit_reached", 128'(ok), 128'(1));
        @(posedge Clk); #1;
        RstN = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        check_all_zero("reset_mid_emit");
        model_reset();
        @(posedge Clk); #1;
        RstN = 1'b1;
        @(posedge Clk); #1;
        send_block(rnd128(), 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/aes_mode_ctrl.md
# aes_mode_ctrl

- Block-chaining mode controller between the byte-oriented host path and the AESCipher core.
- Accepts 128-bit plaintext blocks on AXI-Stream and applies ECB, CBC or CTR chaining around the core.
- Reassembles the core's narrow ciphertext stream into a 128-bit block, then re-serialises the mode-corrected result at a parametrised output width.
- Successor to the fixed 8-bit, ECB-only cipher datapath.

## Interface
- OUT_W, 8 — m_axis data width; one of 8/16/32/64/128.
- CORE_W, 8 — width of the core result stream; one of 8/16/32/64/128.
- Clk  input  1  clock.
- RstN  input  1  synchronous, active-low reset.
- Mode  input  2  00 ECB, 01 CBC, 10 CTR, 11 reserved (treated as ECB); sampled on IvLoad.
- Iv  input  128  CBC initial vector or CTR initial counter; sampled on IvLoad.
- IvLoad  input  1  single-cycle pulse; latches Mode and Iv and restarts the chain.
- s_axis  taxi_axis_if.snk  DATA_W=128  plaintext blocks; tlast marks message end.
- m_axis  taxi_axis_if.src  DATA_W=OUT_W  result beats, MSB-first.
- core_m_axis  taxi_axis_if.src  DATA_W=128  block to AESCipher s_axis.
- core_s_axis  taxi_axis_if.snk  DATA_W=CORE_W  result from AESCipher m_axis.
- Busy  output  1  high in every state except IDLE.

## Operation
- Registers:
  - ModeR
  - ChainR, 128 bits: holds the previous ciphertext in CBC and the counter in CTR.
  - PlainR, 128 bits
  - ColR, 128 bits: collection buffer.
  - Beat counter and pending-IvLoad flag.
- FSM states are IDLE, ISSUE, COLLECT and EMIT.
- IDLE:
  - s_axis.tready = 1 unless IvLoad is high or IvLoad is pending.
  - On handshake: capture the block into PlainR, record tlast, go to ISSUE.
- ISSUE: drive core_m_axis with the mode operand.
  - ECB: P.
  - CBC: P xor ChainR.
  - CTR: ChainR.
  - Hold tvalid and tdata until core tready, then go to COLLECT.
- COLLECT:
  - core_s_axis.tready = 1.
  - Shift each CORE_W beat into ColR, MSB-first.
  - After 128/CORE_W beats, form the result R and go to EMIT.
  - ECB: R = ColR.
  - CBC: R = ColR, and ChainR <= ColR.
  - CTR: R = PlainR xor ColR, and ChainR <= ChainR + 1 mod 2^128 (all-ones wraps to zero).
- EMIT:
  - Present R as 128/OUT_W beats, most significant slice first.
  - m_axis.tlast = 1 on the final beat only if the input block had tlast; otherwise 0.
  - After the final handshake, return to IDLE.
- Message boundary: after emitting a tlast block, ChainR reloads the last latched Iv so the next message starts fresh.
- IvLoad in IDLE: applied in the same cycle; IvLoad wins over a simultaneous s_axis.tvalid and the block is not accepted.
- IvLoad in any other state:
  - Set the pending flag; the current block completes with the old mode and chain.
  - The latch is applied on the IDLE entry cycle, with tready held low that cycle.
- Unused tkeep/tstrb/tid/tdest/tuser outputs drive 0.

## Timing
- All outputs are registered. After RstN low, every output is 0:
  - s_axis.tready
  - m_axis.tvalid/tdata/tlast
  - core_m_axis.tvalid/tdata
  - core_s_axis.tready
  - Busy
- Register reset values: ModeR = ECB, ChainR = 0, all counters 0.
- Input handshake at cycle T → core_m_axis.tvalid at T+1.
- Last core beat accepted at cycle C → m_axis.tvalid at C+1.
- m_axis beat rate is one per cycle with tready held high; total drain is 128/OUT_W cycles.
- Next s_axis.tready at the cycle after the final m_axis handshake.
- AXIS rules:
  - tvalid/tdata stay stable while tready is low.
  - tvalid never depends combinationally on tready.
- Reset mid-operation: return to IDLE next cycle.
  - The partial block is discarded and the pending flag is cleared.
  - The core must share RstN so that no stale core beats arrive.
- One block is in flight at a time; this is required by CBC and also applied to ECB/CTR.

## Configuration
- AES_MODE_CTR_EN defined:
  - CTR path is present: counter adder and PlainR xor.
- AES_MODE_CTR_EN undefined:
  - Adder and PlainR xor are removed.
  - Mode 10 is latched as ECB, and the block output equals the core output.

## Test plan
- ECB, AES-128, OUT_W=8: key 000102…0f, P 00112233445566778899aabbccddeeff → 16 beats 69 c4 … 5a; tlast on beat 16 only when input tlast=1.
- CBC, OUT_W=32: key 2b7e151628aed2a6abf7158809cf4f3c, IvLoad with Iv 000102…0f.
  - P1 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d.
  - P2 ae2d8a571e03ac9c9eb76fac45af8e51 → 5086cb9b507219ee95db113a917678b2.
- CTR, OUT_W=128: same key, Iv f0f1…feff.
  - P1 → 874d6191b620e3261bef6864990db6ce.
  - P2 → 9806f66b7970fdff8617187bb9fffdff.
  - Rebuilt without AES_MODE_CTR_EN, P1 → ECB result 3ad77bb40d7a3660a89ecaf32466ef97.
- Counter wrap: Iv all-ones, two CTR blocks → second core operand is 0.
- m_axis.tready toggling 1/0 every cycle, OUT_W=16 → data stable while stalled and 8 beats in order.
- IvLoad asserted during COLLECT → current block uses the old chain; next block uses the new Iv. RstN low mid-EMIT → all outputs 0 next cycle.
